// File: rtl/startup_screen.sv
// Pong start screen: a title that slides into place, a blinking prompt and a key-to-start handoff, rendered as one overlay bit.
// Build option: define STARTUP_ATTRACT_EN to enable the idle timeout that sends WAIT back to INTRO.

module startup_screen #(
    parameter int                       TITLE_LEN      = 4,
    parameter logic [8*TITLE_LEN-1:0]   TITLE_TEXT     = "PONG",
    parameter int                       TITLE_SCALE    = 8,
    parameter int                       PROMPT_LEN     = 22,
    parameter logic [8*PROMPT_LEN-1:0]  PROMPT_TEXT    = "Press any key to start",
    parameter int                       PROMPT_SCALE   = 2,
    parameter int                       KERNING        = 4,
    parameter int                       TITLE_X        = 186,
    parameter int                       TITLE_Y        = 99,
    parameter int                       PROMPT_X       = 102,
    parameter int                       PROMPT_Y       = 300,
    parameter int                       SLIDE_START_Y  = 0,
    parameter int                       SLIDE_STEP     = 4,
    parameter int                       BLINK_FRAMES   = 30,
    parameter int                       ATTRACT_FRAMES = 600
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic       show,
    input  logic       key_pressed,
    output logic [7:0] font_char,
    output logic [2:0] font_row,
    input  logic [7:0] font_bits,
    output logic       in_text,
    output logic       start_game,
    output logic       active,
    output logic       attract
);

    localparam int T_GLYPH = 8 * TITLE_SCALE;
    localparam int T_PITCH = T_GLYPH + KERNING;
    localparam int T_WIDTH = TITLE_LEN * T_PITCH - KERNING;
    localparam int P_GLYPH = 8 * PROMPT_SCALE;
    localparam int P_PITCH = P_GLYPH + KERNING;
    localparam int P_WIDTH = PROMPT_LEN * P_PITCH - KERNING;
    localparam int BW      = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INTRO = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      title_y_q, title_y_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic            hit_q, hit_d;
    logic [2:0]      col_q, col_d;
    logic            in_text_q, in_text_d;
    logic            start_game_q, start_game_d;

    logic [10:0]     slide_sum;
    logic [9:0]      slide_y;

    logic            title_on, prompt_on;
    logic [10:0]     t_dx, t_dy, t_mod, t_idx;
    logic [10:0]     p_dx, p_dy, p_mod, p_idx;
    logic            t_hit, p_hit;

`ifdef STARTUP_ATTRACT_EN
    localparam int AW = $clog2(ATTRACT_FRAMES + 1);
    logic [AW-1:0]   attract_cnt_q, attract_cnt_d;
    logic            attract_q, attract_d;
`endif

    function automatic logic [7:0] title_char(input logic [10:0] idx);
        title_char = 8'h20;
        for (int i = 0; i < TITLE_LEN; i++) begin
            if (idx == 11'(i)) title_char = TITLE_TEXT[8*(TITLE_LEN-1-i) +: 8];
        end
    endfunction

    function automatic logic [7:0] prompt_char(input logic [10:0] idx);
        prompt_char = 8'h20;
        for (int i = 0; i < PROMPT_LEN; i++) begin
            if (idx == 11'(i)) prompt_char = PROMPT_TEXT[8*(PROMPT_LEN-1-i) +: 8];
        end
    endfunction

    // Slide position saturates at the resting row; the extra bit keeps the sum from wrapping.
    assign slide_sum = {1'b0, title_y_q} + 11'(SLIDE_STEP);
    assign slide_y   = (slide_sum >= 11'(TITLE_Y)) ? 10'(TITLE_Y) : slide_sum[9:0];

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            title_y_q    <= 10'(SLIDE_START_Y);
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            hit_q        <= 1'b0;
            col_q        <= 3'd0;
            in_text_q    <= 1'b0;
            start_game_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            title_y_q    <= title_y_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            hit_q        <= hit_d;
            col_q        <= col_d;
            in_text_q    <= in_text_d;
            start_game_q <= start_game_d;
        end
    end

`ifdef STARTUP_ATTRACT_EN
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            attract_cnt_q <= '0;
            attract_q     <= 1'b0;
        end else begin
            attract_cnt_q <= attract_cnt_d;
            attract_q     <= attract_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        title_y_d   = title_y_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
`ifdef STARTUP_ATTRACT_EN
        attract_cnt_d = attract_cnt_q;
        attract_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                title_y_d   = 10'(SLIDE_START_Y);
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
`ifdef STARTUP_ATTRACT_EN
                attract_cnt_d = '0;
`endif
                if (show) state_d = ST_INTRO;
            end
            ST_INTRO: begin
                // A key press skips the slide; it takes priority over a same-cycle frame tick.
                if (!show) begin
                    state_d = ST_IDLE;
                end else if (key_pressed) begin
                    title_y_d   = 10'(TITLE_Y);
                    state_d     = ST_WAIT;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
`ifdef STARTUP_ATTRACT_EN
                    attract_cnt_d = '0;
`endif
                end else if (frame_tick) begin
                    title_y_d = slide_y;
                    if (slide_y == 10'(TITLE_Y)) begin
                        state_d     = ST_WAIT;
                        blink_cnt_d = '0;
                        blink_on_d  = 1'b1;
`ifdef STARTUP_ATTRACT_EN
                        attract_cnt_d = '0;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (!show) begin
                    state_d = ST_IDLE;
                end else if (key_pressed) begin
                    state_d = ST_DONE;
                end else if (frame_tick) begin
                    if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
`ifdef STARTUP_ATTRACT_EN
                    if (attract_cnt_q == AW'(ATTRACT_FRAMES - 1)) begin
                        attract_cnt_d = '0;
                        attract_d     = 1'b1;
                        state_d       = ST_INTRO;
                        title_y_d     = 10'(SLIDE_START_Y);
                    end else begin
                        attract_cnt_d = attract_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_game_d = (state_d == ST_DONE);
    end

    assign title_on  = (state_q == ST_INTRO) || (state_q == ST_WAIT);
    assign prompt_on = (state_q == ST_WAIT) && blink_on_q;

    // Offsets are 11 bits wide so that bit 10 flags a pixel above or left of the line.
    assign t_dx  = {1'b0, pixel_x} - 11'(TITLE_X);
    assign t_dy  = {1'b0, pixel_y} - {1'b0, title_y_q};
    assign t_mod = t_dx % 11'(T_PITCH);
    assign t_idx = t_dx / 11'(T_PITCH);
    assign t_hit = title_on && !t_dx[10] && (t_dx < 11'(T_WIDTH)) &&
                   !t_dy[10] && (t_dy < 11'(T_GLYPH)) && (t_mod < 11'(T_GLYPH));

    assign p_dx  = {1'b0, pixel_x} - 11'(PROMPT_X);
    assign p_dy  = {1'b0, pixel_y} - 11'(PROMPT_Y);
    assign p_mod = p_dx % 11'(P_PITCH);
    assign p_idx = p_dx / 11'(P_PITCH);
    assign p_hit = prompt_on && !p_dx[10] && (p_dx < 11'(P_WIDTH)) &&
                   !p_dy[10] && (p_dy < 11'(P_GLYPH)) && (p_mod < 11'(P_GLYPH));

    always_comb begin
        font_char = 8'h20;
        font_row  = 3'd0;
        hit_d     = 1'b0;
        col_d     = 3'd0;
        if (t_hit) begin
            font_char = title_char(t_idx);
            font_row  = 3'(t_dy / 11'(TITLE_SCALE));
            hit_d     = 1'b1;
            col_d     = 3'(t_mod / 11'(TITLE_SCALE));
        end else if (p_hit) begin
            font_char = prompt_char(p_idx);
            font_row  = 3'(p_dy / 11'(PROMPT_SCALE));
            hit_d     = 1'b1;
            col_d     = 3'(p_mod / 11'(PROMPT_SCALE));
        end
    end

    // ROM data arrives one cycle after the request, aligned with hit_q/col_q; bit 7 is the leftmost column.
    always_comb begin
        in_text_d = hit_q & font_bits[~col_q];
    end

    assign in_text    = in_text_q;
    assign start_game = start_game_q;
    assign active     = (state_q != ST_IDLE);

`ifdef STARTUP_ATTRACT_EN
    assign attract = attract_q;
`else
    // Timeout logic is compiled out; attract stays low.
    assign attract = 1'b0 && (ATTRACT_FRAMES > 0);
`endif

endmodule
